// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit_pkg
// Description : Shared codes for the writeback unit: write-back modes,
//               register selector codes (common with the fetcher), FSM state
//               encodings and the default stack page base.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_unit_pkg;

  // Write-back destination modes
  localparam logic [1:0] WB_NONE = 2'd0;
  localparam logic [1:0] WB_REG  = 2'd1;
  localparam logic [1:0] WB_MEM  = 2'd2;
  localparam logic [1:0] WB_PUSH = 2'd3;

  // Register selector codes, common with the instruction fetcher
  localparam logic [3:0] SELECTOR_A   = 4'd0;
  localparam logic [3:0] SELECTOR_X   = 4'd1;
  localparam logic [3:0] SELECTOR_Y   = 4'd2;
  localparam logic [3:0] SELECTOR_SP  = 4'd3;
  localparam logic [3:0] SELECTOR_P   = 4'd4;
  localparam logic [3:0] SELECTOR_PCL = 4'd5;
  localparam logic [3:0] SELECTOR_PCH = 4'd6;

  // The 6502 stack lives in page 1
  localparam logic [15:0] STACK_BASE_DEFAULT = 16'h0100;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REG   = 3'd1,
    ST_MEM   = 3'd2,
    ST_PUSH  = 3'd3,
    ST_SPUPD = 3'd4,
    ST_DONE  = 3'd5
  } wb_state_e;

  // A push count of zero is treated as a single-byte push
  function automatic logic [1:0] eff_count(input logic [1:0] cnt);
    return (cnt == 2'd0) ? 2'd1 : cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit_if
// Description : Request and write-bus signals of the writeback unit. The
//               master side is the execute stage / memory system, the slave
//               side is the writeback unit itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_unit_if #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);

  // Request from the execute stage
  logic                     wb_start;
  logic [1:0]               wb_mode;
  logic [1:0]               wb_count;
  logic [3:0]               wb_target;
  logic [ADDR_WIDTH-1:0]    wb_addr;
  logic [3*REG_WIDTH-1:0]   wb_data;
  logic [REG_WIDTH-1:0]     sp_in;

  // Write bus and status back to the core
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [REG_WIDTH-1:0]     mem_data_out;
  logic                     mem_we;
  logic [3:0]               reg_sel;
  logic [REG_WIDTH-1:0]     reg_data;
  logic                     reg_we;
  logic [REG_WIDTH-1:0]     sp_out;
  logic                     sp_we;
  logic                     wb_busy;
  logic                     wb_done;

  modport master (
    output wb_start, wb_mode, wb_count, wb_target, wb_addr, wb_data, sp_in,
    input  mem_addr, mem_data_out, mem_we, reg_sel, reg_data, reg_we,
           sp_out, sp_we, wb_busy, wb_done
  );

  modport slave (
    input  wb_start, wb_mode, wb_count, wb_target, wb_addr, wb_data, sp_in,
    output mem_addr, mem_data_out, mem_we, reg_sel, reg_data, reg_we,
           sp_out, sp_we, wb_busy, wb_done
  );

endinterface
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Commits one execute-stage result to a register, a memory
//               byte, or a 1..3 byte push onto the page-1 stack followed by a
//               stack pointer update, then pulses wb_done.
//               All strobes and their address/data are registered: the value
//               each one takes in a state is computed on the edge that enters
//               that state.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int                    REG_WIDTH  = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = ADDR_WIDTH'(STACK_BASE_DEFAULT)
) (
  input  logic             phi1,
  input  logic             reset_n,
  writeback_unit_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State and latched request
  // --------------------------------------------------------------------------
  wb_state_e               state_q,  state_d;
  logic [3*REG_WIDTH-1:0]  data_q,   data_d;
  logic [REG_WIDTH-1:0]    sp_in_q,  sp_in_d;   // sp at acceptance
  logic [1:0]              count_q,  count_d;   // effective count 1..3
  logic [1:0]              idx_q,    idx_d;     // byte index being written
  logic [REG_WIDTH-1:0]    sp_q,     sp_d;      // sp of the byte being written

  // Registered outputs
  logic [ADDR_WIDTH-1:0]   mem_addr_q,     mem_addr_d;
  logic [REG_WIDTH-1:0]    mem_data_q,     mem_data_d;
  logic                    mem_we_q,       mem_we_d;
  logic [3:0]              reg_sel_q,      reg_sel_d;
  logic [REG_WIDTH-1:0]    reg_data_q,     reg_data_d;
  logic                    reg_we_q,       reg_we_d;
  logic [REG_WIDTH-1:0]    sp_out_q,       sp_out_d;
  logic                    sp_we_q,        sp_we_d;
  logic                    wb_done_q,      wb_done_d;

  // Helpers for the push path
  logic [1:0]              start_count;
  logic [1:0]              start_idx;
  logic [1:0]              idx_dec;
  logic [REG_WIDTH-1:0]    sp_dec;

  assign start_count = eff_count(bus.wb_count);
  assign start_idx   = start_count - 2'd1;
  assign idx_dec     = idx_q - 2'd1;
  assign sp_dec      = sp_q - REG_WIDTH'(1);

  // Selects byte k of the packed result word
  function automatic logic [REG_WIDTH-1:0] byte_at(
    input logic [3*REG_WIDTH-1:0] d,
    input logic [1:0]             k
  );
    case (k)
      2'd0:    return d[REG_WIDTH-1:0];
      2'd1:    return d[2*REG_WIDTH-1:REG_WIDTH];
      default: return d[3*REG_WIDTH-1:2*REG_WIDTH];
    endcase
  endfunction

  // Stack address: sp only supplies the low byte, so the push stays in page 1
  function automatic logic [ADDR_WIDTH-1:0] stack_addr(
    input logic [REG_WIDTH-1:0] sp
  );
    return STACK_BASE | ADDR_WIDTH'(sp);
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    sp_in_d    = sp_in_q;
    count_d    = count_q;
    idx_d      = idx_q;
    sp_d       = sp_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    reg_sel_d  = reg_sel_q;
    reg_data_d = reg_data_q;
    sp_out_d   = sp_out_q;
    mem_we_d   = 1'b0;
    reg_we_d   = 1'b0;
    sp_we_d    = 1'b0;
    wb_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.wb_start) begin
          data_d  = bus.wb_data;
          sp_in_d = bus.sp_in;
          count_d = start_count;
          case (bus.wb_mode)
            WB_REG: begin
              state_d    = ST_REG;
              reg_we_d   = 1'b1;
              reg_sel_d  = bus.wb_target;
              reg_data_d = bus.wb_data[REG_WIDTH-1:0];
            end
            WB_MEM: begin
              state_d    = ST_MEM;
              mem_we_d   = 1'b1;
              mem_addr_d = bus.wb_addr;
              mem_data_d = bus.wb_data[REG_WIDTH-1:0];
            end
            WB_PUSH: begin
              // Highest byte goes first, at the current sp
              state_d    = ST_PUSH;
              idx_d      = start_idx;
              sp_d       = bus.sp_in;
              mem_we_d   = 1'b1;
              mem_addr_d = stack_addr(bus.sp_in);
              mem_data_d = byte_at(bus.wb_data, start_idx);
            end
            default: begin
              state_d   = ST_DONE;
              wb_done_d = 1'b1;
            end
          endcase
        end
      end

      ST_REG, ST_MEM: begin
        state_d   = ST_DONE;
        wb_done_d = 1'b1;
      end

      ST_PUSH: begin
        if (idx_q == 2'd0) begin
          state_d  = ST_SPUPD;
          sp_we_d  = 1'b1;
          sp_out_d = sp_in_q - REG_WIDTH'(count_q);
        end else begin
          // Next lower byte one slot further down; sp wraps within the page
          idx_d      = idx_dec;
          sp_d       = sp_dec;
          mem_we_d   = 1'b1;
          mem_addr_d = stack_addr(sp_dec);
          mem_data_d = byte_at(data_q, idx_dec);
        end
      end

      ST_SPUPD: begin
        state_d   = ST_DONE;
        wb_done_d = 1'b1;
      end

      ST_DONE: begin
        // A request arriving here is deliberately dropped
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any sequence immediately
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      sp_in_q    <= '0;
      count_q    <= 2'd1;
      idx_q      <= 2'd0;
      sp_q       <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      reg_sel_q  <= 4'd0;
      reg_data_q <= '0;
      reg_we_q   <= 1'b0;
      sp_out_q   <= '0;
      sp_we_q    <= 1'b0;
      wb_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      sp_in_q    <= sp_in_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      sp_q       <= sp_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      reg_sel_q  <= reg_sel_d;
      reg_data_q <= reg_data_d;
      reg_we_q   <= reg_we_d;
      sp_out_q   <= sp_out_d;
      sp_we_q    <= sp_we_d;
      wb_done_q  <= wb_done_d;
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_out = mem_data_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.reg_sel      = reg_sel_q;
  assign bus.reg_data     = reg_data_q;
  assign bus.reg_we       = reg_we_q;
  assign bus.sp_out       = sp_out_q;
  assign bus.sp_we        = sp_we_q;
  assign bus.wb_done      = wb_done_q;
  assign bus.wb_busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Self-checking bench for writeback_unit. A queue-based model
//               lists the expected bus activity of each accepted request
//               cycle by cycle; directed requests also carry literal
//               expectations for addresses, data and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  logic phi1    = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;

  writeback_unit_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  writeback_unit #(
    .REG_WIDTH (8),
    .ADDR_WIDTH(16),
    .STACK_BASE(16'h0100)
  ) dut (
    .phi1   (phi1),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 phi1 = ~phi1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: one entry per cycle of expected activity after acceptance
  // --------------------------------------------------------------------------
  typedef struct {
    bit          mwe;
    logic [15:0] a;
    logic [7:0]  d;
    bit          rwe;
    logic [3:0]  sel;
    logic [7:0]  rd;
    bit          swe;
    logic [7:0]  sp;
    bit          done;
  } exp_t;

  exp_t q[$];

  function automatic exp_t blank();
    exp_t e;
    e = '{mwe: 1'b0, a: 16'h0, d: 8'h0, rwe: 1'b0, sel: 4'h0, rd: 8'h0,
          swe: 1'b0, sp: 8'h0, done: 1'b0};
    return e;
  endfunction

  function automatic void model_accept();
    exp_t        e;
    int          c;
    int          s;
    logic [23:0] dd;
    dd = bus.wb_data;
    s  = int'(bus.sp_in);
    case (bus.wb_mode)
      WB_REG: begin
        e = blank(); e.rwe = 1; e.sel = bus.wb_target; e.rd = dd[7:0]; q.push_back(e);
      end
      WB_MEM: begin
        e = blank(); e.mwe = 1; e.a = bus.wb_addr; e.d = dd[7:0]; q.push_back(e);
      end
      WB_PUSH: begin
        c = (bus.wb_count == 2'd0) ? 1 : int'(bus.wb_count);
        for (int j = 0; j < c; j++) begin
          e = blank();
          e.mwe = 1;
          e.a   = 16'h0100 + 16'((s - j) & 255);
          e.d   = 8'(dd >> (8 * (c - 1 - j)));
          q.push_back(e);
        end
        e = blank(); e.swe = 1; e.sp = 8'((s - c) & 255); q.push_back(e);
      end
      default: ;
    endcase
    e = blank(); e.done = 1; q.push_back(e);
  endfunction

  bit m_was_busy;
  always @(posedge phi1) begin
    cyc++;
    if (reset_n) begin
      m_was_busy = (q.size() > 0);
      if (m_was_busy) void'(q.pop_front());
      if (!m_was_busy && bus.wb_start === 1'b1) model_accept();
    end
  end

  always @(negedge reset_n) q.delete();

  // --------------------------------------------------------------------------
  // Compare process and activity logs
  // --------------------------------------------------------------------------
  logic [23:0] mem_log[$];
  logic [11:0] reg_log[$];
  logic [7:0]  sp_log[$];
  int          done_log[$];
  exp_t        cur;

  always @(negedge phi1) begin
    if (reset_n) begin
      cur = (q.size() > 0) ? q[0] : blank();
      check("mem_we",  32'(bus.mem_we),  32'(cur.mwe));
      check("reg_we",  32'(bus.reg_we),  32'(cur.rwe));
      check("sp_we",   32'(bus.sp_we),   32'(cur.swe));
      check("wb_done", 32'(bus.wb_done), 32'(cur.done));
      check("wb_busy", 32'(bus.wb_busy), 32'(q.size() > 0));
      if (cur.mwe) begin
        check("mem_addr", 32'(bus.mem_addr),     32'(cur.a));
        check("mem_data", 32'(bus.mem_data_out), 32'(cur.d));
      end
      if (cur.rwe) begin
        check("reg_sel",  32'(bus.reg_sel),  32'(cur.sel));
        check("reg_data", 32'(bus.reg_data), 32'(cur.rd));
      end
      if (cur.swe) check("sp_out", 32'(bus.sp_out), 32'(cur.sp));
      if (bus.mem_we === 1'b1)  mem_log.push_back({bus.mem_addr, bus.mem_data_out});
      if (bus.reg_we === 1'b1)  reg_log.push_back({bus.reg_sel, bus.reg_data});
      if (bus.sp_we === 1'b1)   sp_log.push_back(bus.sp_out);
      if (bus.wb_done === 1'b1) done_log.push_back(cyc);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic clear_logs();
    mem_log.delete(); reg_log.delete(); sp_log.delete(); done_log.delete();
  endtask

  task automatic set_req(input logic [1:0] mode, input logic [1:0] cnt, input logic [3:0] tgt,
                         input logic [15:0] addr, input logic [23:0] data, input logic [7:0] sp);
    bus.wb_mode = mode; bus.wb_count = cnt; bus.wb_target = tgt;
    bus.wb_addr = addr; bus.wb_data = data; bus.sp_in = sp;
  endtask

  // One-cycle start strobe; inputs are scrambled afterwards so any late
  // sampling by the design shows up as wrong data.
  task automatic request(input logic [1:0] mode, input logic [1:0] cnt, input logic [3:0] tgt,
                         input logic [15:0] addr, input logic [23:0] data, input logic [7:0] sp,
                         output int acc);
    @(negedge phi1);
    set_req(mode, cnt, tgt, addr, data, sp);
    bus.wb_start = 1'b1;
    acc = cyc;
    @(negedge phi1);
    bus.wb_start = 1'b0;
    set_req(2'($urandom), 2'($urandom), 4'($urandom), 16'($urandom), 24'($urandom), 8'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.wb_busy !== 1'b0 && n < 30) begin
      @(negedge phi1);
      n++;
    end
    if (n >= 30) check("busy_timeout", 32'd1, 32'd0);
    @(negedge phi1);
  endtask

  initial begin
    int acc;
    bus.wb_start = 1'b0;
    set_req(2'd0, 2'd0, 4'd0, 16'd0, 24'd0, 8'd0);

    // Reset values
    #1 reset_n = 1'b0;
    #1;
    check("rst_mem_we",   32'(bus.mem_we),       32'd0);
    check("rst_reg_we",   32'(bus.reg_we),       32'd0);
    check("rst_sp_we",    32'(bus.sp_we),        32'd0);
    check("rst_busy",     32'(bus.wb_busy),      32'd0);
    check("rst_done",     32'(bus.wb_done),      32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr),     32'd0);
    check("rst_mem_data", 32'(bus.mem_data_out), 32'd0);
    check("rst_reg_sel",  32'(bus.reg_sel),      32'd0);
    check("rst_reg_data", 32'(bus.reg_data),     32'd0);
    check("rst_sp_out",   32'(bus.sp_out),       32'd0);
    repeat (2) @(negedge phi1);
    reset_n = 1'b1;
    @(negedge phi1);

    // WB_NONE: done one cycle after acceptance
    clear_logs();
    request(WB_NONE, 2'd0, SELECTOR_A, 16'h0000, 24'h0, 8'h00, acc);
    wait_idle();
    check("none_lat", 32'(done_log[0] - acc), 32'd1);
    check("none_writes", 32'(mem_log.size() + reg_log.size() + sp_log.size()), 32'd0);

    // WB_REG
    clear_logs();
    request(WB_REG, 2'd0, SELECTOR_X, 16'h1111, 24'h00005A, 8'h33, acc);
    wait_idle();
    check("reg_n",   32'(reg_log.size()), 32'd1);
    check("reg_w",   32'(reg_log[0]),     32'({SELECTOR_X, 8'h5A}));
    check("reg_lat", 32'(done_log[0] - acc), 32'd2);
    check("reg_other", 32'(mem_log.size() + sp_log.size()), 32'd0);

    // WB_MEM
    clear_logs();
    request(WB_MEM, 2'd2, SELECTOR_Y, 16'h0234, 24'hFFEEC3, 8'h44, acc);
    wait_idle();
    check("mem_n",   32'(mem_log.size()), 32'd1);
    check("mem_w",   32'(mem_log[0]),     32'h0234C3);
    check("mem_lat", 32'(done_log[0] - acc), 32'd2);
    check("mem_other", 32'(reg_log.size() + sp_log.size()), 32'd0);

    // PUSH 2
    clear_logs();
    request(WB_PUSH, 2'd2, SELECTOR_A, 16'h9999, 24'h991234, 8'hFD, acc);
    wait_idle();
    check("p2_n",   32'(mem_log.size()), 32'd2);
    check("p2_w0",  32'(mem_log[0]),     32'h01FD12);
    check("p2_w1",  32'(mem_log[1]),     32'h01FC34);
    check("p2_sp",  32'(sp_log[0]),      32'hFB);
    check("p2_lat", 32'(done_log[0] - acc), 32'd4);

    // PUSH 3 wrapping through sp=0x00
    clear_logs();
    request(WB_PUSH, 2'd3, SELECTOR_A, 16'h0000, 24'hAABBCC, 8'h01, acc);
    wait_idle();
    check("p3_w0",  32'(mem_log[0]), 32'h0101AA);
    check("p3_w1",  32'(mem_log[1]), 32'h0100BB);
    check("p3_w2",  32'(mem_log[2]), 32'h01FFCC);
    check("p3_sp",  32'(sp_log[0]),  32'hFE);
    check("p3_lat", 32'(done_log[0] - acc), 32'd5);

    // PUSH with count 0 behaves as a single byte
    clear_logs();
    request(WB_PUSH, 2'd0, SELECTOR_A, 16'h0000, 24'h123477, 8'h10, acc);
    wait_idle();
    check("p0_n",  32'(mem_log.size()), 32'd1);
    check("p0_w0", 32'(mem_log[0]),     32'h011077);
    check("p0_sp", 32'(sp_log[0]),      32'h0F);

    // wb_start held through a PUSH 2: ignored while busy and during DONE,
    // the next request only starts once the unit is idle again
    clear_logs();
    @(negedge phi1);
    set_req(WB_PUSH, 2'd2, SELECTOR_A, 16'h0000, 24'h00A1B2, 8'hF0);
    bus.wb_start = 1'b1;
    acc = cyc;
    repeat (6) @(negedge phi1);
    bus.wb_start = 1'b0;
    wait_idle();
    check("busy_writes", 32'(mem_log.size()), 32'd4);
    check("busy_sp_n",   32'(sp_log.size()),  32'd2);
    check("busy_done0",  32'(done_log[0] - acc), 32'd4);
    check("busy_done1",  32'(done_log[1] - acc), 32'd9);

    // Reset right after the first push byte
    clear_logs();
    request(WB_PUSH, 2'd3, SELECTOR_A, 16'h0000, 24'h112233, 8'h80, acc);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_mem_we", 32'(bus.mem_we),  32'd0);
    check("mrst_sp_we",  32'(bus.sp_we),   32'd0);
    check("mrst_busy",   32'(bus.wb_busy), 32'd0);
    check("mrst_done",   32'(bus.wb_done), 32'd0);
    repeat (2) @(negedge phi1);
    reset_n = 1'b1;
    repeat (3) @(negedge phi1);
    check("mrst_n",    32'(mem_log.size()), 32'd1);
    check("mrst_w0",   32'(mem_log[0]),     32'h018011);
    check("mrst_tail", 32'(sp_log.size() + done_log.size()), 32'd0);

    // A fresh request is accepted after reset
    clear_logs();
    request(WB_REG, 2'd0, SELECTOR_A, 16'h0000, 24'h00003C, 8'h00, acc);
    wait_idle();
    check("post_reg", 32'(reg_log[0]), 32'({SELECTOR_A, 8'h3C}));
    check("post_lat", 32'(done_log[0] - acc), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
# writeback_unit

Write-side companion to the instruction fetcher. It accepts one result from the execute stage and commits it to one of three destinations:
- a CPU register;
- a single memory byte;
- a 1–3 byte push sequence onto the 6502 stack in page 1, with a stack-pointer update.

It sequences these as explicit bus write cycles and reports completion so the fetcher can start the next instruction.

## Interface
Parameters:
- REG_WIDTH, 8, data/register width
- ADDR_WIDTH, 16, memory address width
- STACK_BASE, 16'h0100, base address of stack page

Ports:
- phi1  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_start  in  1  request strobe, accepted on a phi1 edge when wb_busy=0
- wb_mode  in  2  WB_NONE=0, WB_REG=1, WB_MEM=2, WB_PUSH=3
- wb_count  in  2  push byte count 1..3; 0 treated as 1; ignored unless WB_PUSH
- wb_target  in  4  register selector code (shared SELECTOR_* codes)
- wb_addr  in  ADDR_WIDTH  memory target for WB_MEM
- wb_data  in  3*REG_WIDTH  byte k at [8k+7:8k]; WB_REG/WB_MEM use byte 0
- sp_in  in  REG_WIDTH  current stack pointer
- mem_addr  out  ADDR_WIDTH  write address
- mem_data_out  out  REG_WIDTH  write data
- mem_we  out  1  memory write strobe, one cycle per byte
- reg_sel  out  4  register selector
- reg_data  out  REG_WIDTH  register write data
- reg_we  out  1  register write strobe
- sp_out  out  REG_WIDTH  new stack pointer
- sp_we  out  1  stack pointer write strobe
- wb_busy  out  1  high whenever state != IDLE
- wb_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, REG, MEM, PUSH, SPUPD, DONE.
- Acceptance: in IDLE with wb_start=1, the following are latched on the phi1 edge: wb_mode, wb_count, wb_target, wb_addr, wb_data and sp_in. Input changes after acceptance have no effect.
- Transitions from IDLE on acceptance:
  - WB_NONE→DONE
  - WB_REG→REG
  - WB_MEM→MEM
  - WB_PUSH→PUSH, with byte index i = count-1
- REG: one cycle with reg_we=1, reg_sel=target, reg_data=byte0; then DONE.
- MEM: one cycle with mem_we=1, mem_addr=wb_addr, mem_data_out=byte0; then DONE.
- PUSH: one cycle per byte, highest index first. For a 3-byte push of {PCH,PCL,P}, the order is PCH, PCL, P.
  - Each cycle: mem_we=1, mem_addr = STACK_BASE | {8'h00, sp}, mem_data_out = byte[i].
  - Then sp = sp - 1, modulo 2^8 (0x00 wraps to 0xFF; the address never leaves page 1), and i decrements.
  - After the byte at i=0 is written, go to SPUPD.
- SPUPD: one cycle with sp_we=1, sp_out = latched sp_in - count (mod 256); then DONE.
- DONE: one cycle with wb_done=1; then IDLE.
- wb_start is ignored while wb_busy=1. There is no queueing, and a request raised during DONE is lost.
- Strobes are mutually exclusive: at most one of mem_we, reg_we, sp_we is high in any cycle.

## Timing
- Reset values (async, immediate): state IDLE; mem_we, reg_we, sp_we, wb_busy, wb_done = 0; mem_addr, mem_data_out, reg_sel, reg_data, sp_out = 0.
- Latency from the acceptance edge to the wb_done cycle:
  - WB_NONE: 1 cycle
  - REG, MEM: 2 cycles
  - PUSH: count+2 cycles
- wb_busy rises in the cycle after acceptance and falls in the cycle after DONE.
- Strobes and their address/data are registered outputs, valid for the whole cycle in which the strobe is high.
- Reset mid-operation: the sequence is abandoned at once. There is no further mem_we, and no sp_we or wb_done. Stack bytes already written remain in memory.

## Structure
- The shared defines header holds:
  - WB_NONE/WB_REG/WB_MEM/WB_PUSH codes
  - the SELECTOR_* register codes, shared with the fetcher
  - the state encodings
  - the STACK_BASE default
- Single flat module; no sub-module is needed.
- The push address/decrement logic stays inline.

## Test plan
- REG: mode=1, target=SELECTOR_X, byte0=0x5A → exactly one cycle with reg_we=1, reg_sel=SELECTOR_X, reg_data=0x5A; wb_done 2 cycles after accept.
- MEM: mode=2, addr=0x0234, byte0=0xC3 → one cycle with mem_we=1 at 0x0234 carrying 0xC3; no reg_we or sp_we.
- PUSH 2: sp_in=0xFD, wb_data={x,0x12,0x34} → writes 0x12@0x01FD, then 0x34@0x01FC; sp_we with sp_out=0xFB; wb_done 4 cycles after accept.
- PUSH 3 with wrap: sp_in=0x01, data={0xAA,0xBB,0xCC} → writes 0xAA@0x0101, 0xBB@0x0100, 0xCC@0x01FF; sp_out=0xFE.
- Busy: wb_start held high throughout a PUSH 2 → only one sequence; a second one starts only after wb_busy=0.
- Reset mid-push: reset_n low after the first push byte → all strobes drop immediately; no sp_we or wb_done; after release, IDLE and a new request is accepted.
